wb_sequencer: RTL and testbench

- Write-side driver for the 32x64 register file: generates the 5-phase instruction counter (0=IF, 1=ID, 2=EX, 3=MEM, 4=WB) and presents rd/wval/regWrite to the register file.
- Latches destination and control at decode, ALU result at end of EX, and load data at end of MEM.
- Performs RV64 load sign/zero extension and issues the register write only in phase 4.
- Stretches MEM with a bounded wait for memory.

---
 rtl/wb_sequencer.sv | 150 +++++++++++++++
 tb/tb_wb_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Write-side sequencer for the register file: runs the 5-phase instruction counter,
// latches decode/EX/MEM results and presents rd/wval/regWrite during WB.
module wb_sequencer #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instr_valid,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [2:0]      counter,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] wval,
  output logic            regWrite,
  output logic            instr_done,
  output logic            mem_err
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    PH_IF  = 3'd0,
    PH_ID  = 3'd1,
    PH_EX  = 3'd2,
    PH_MEM = 3'd3,
    PH_WB  = 3'd4
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic              rw_lat_q, rw_lat_d;
  logic              m2r_lat_q, m2r_lat_d;
  logic [2:0]        f3_lat_q, f3_lat_d;
  logic [XLEN-1:0]   alu_lat_q, alu_lat_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   wval_q, wval_d;
  logic              regwrite_q, regwrite_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    case (f3_lat_q)
      3'b000:  load_ext = {{(XLEN-8){mem_rdata[7]}},   mem_rdata[7:0]};
      3'b001:  load_ext = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010:  load_ext = {{(XLEN-32){mem_rdata[31]}}, mem_rdata[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},           mem_rdata[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}},          mem_rdata[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}},          mem_rdata[31:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    phase_d    = phase_q;
    wait_d     = wait_q;
    rd_lat_d   = rd_lat_q;
    rw_lat_d   = rw_lat_q;
    m2r_lat_d  = m2r_lat_q;
    f3_lat_d   = f3_lat_q;
    alu_lat_d  = alu_lat_q;
    rd_d       = rd_q;
    wval_d     = wval_q;
    regwrite_d = regwrite_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (!stall) begin
      case (phase_q)
        PH_IF: if (instr_valid) phase_d = PH_ID;
        PH_ID: begin
          rd_lat_d  = rd_in;
          rw_lat_d  = reg_write_in;
          m2r_lat_d = mem_to_reg;
          f3_lat_d  = funct3;
          phase_d   = PH_EX;
        end
        PH_EX: begin
          alu_lat_d = alu_result;
          phase_d   = PH_MEM;
        end
        PH_MEM: begin
          if (!m2r_lat_q || mem_ready) begin
            rd_d       = rd_lat_q;
            regwrite_d = rw_lat_q && (rd_lat_q != 5'd0);
            wval_d     = m2r_lat_q ? load_ext : alu_lat_q;
            wait_d     = '0;
            phase_d    = PH_WB;
          end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
            // This low cycle makes the count reach the limit: abort without a write.
            err_d   = 1'b1;
            wait_d  = '0;
            phase_d = PH_IF;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        PH_WB: begin
          regwrite_d = 1'b0;
          done_d     = 1'b1;
          phase_d    = PH_IF;
        end
        default: phase_d = PH_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_IF;
      wait_q     <= '0;
      rd_lat_q   <= '0;
      rw_lat_q   <= 1'b0;
      m2r_lat_q  <= 1'b0;
      f3_lat_q   <= '0;
      alu_lat_q  <= '0;
      rd_q       <= '0;
      wval_q     <= '0;
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      rd_lat_q   <= rd_lat_d;
      rw_lat_q   <= rw_lat_d;
      m2r_lat_q  <= m2r_lat_d;
      f3_lat_q   <= f3_lat_d;
      alu_lat_q  <= alu_lat_d;
      rd_q       <= rd_d;
      wval_q     <= wval_d;
      regwrite_q <= regwrite_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign counter    = phase_q;
  assign rd         = rd_q;
  assign wval       = wval_q;
  assign regWrite   = regwrite_q;
  assign instr_done = done_q;
  assign mem_err    = err_q;
endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed vector table, hand-written
// stall/reset/timeout sequences, and randomized instructions against a reference model.
module tb_wb_sequencer;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, stall, instr_valid, reg_write_in, mem_to_reg, mem_ready;
  logic [4:0]  rd_in, rd;
  logic [2:0]  funct3, counter;
  logic [63:0] alu_result, mem_rdata, wval;
  logic        regWrite, instr_done, mem_err;

  int n_chk = 0;
  int n_fail = 0;

  wb_sequencer #(.XLEN(64), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg(mem_to_reg),
    .funct3(funct3), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .counter(counter), .rd(rd), .wval(wval),
    .regWrite(regWrite), .instr_done(instr_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic        w;
    logic        m;
    logic [2:0]  f;
    logic [63:0] alu;
    logic [63:0] dat;
    logic [63:0] exp_wval;
    logic        exp_rw;
  } vec_t;

  typedef struct {
    logic        seen4, err, done, rw, rw_bad, to, seq_bad;
    logic [4:0]  rd;
    logic [63:0] wval;
    int          p3, cyc;
  } obs_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Load result from width/sign rules: mask to the access width, then fill upward.
  function automatic logic [63:0] ref_ext(input logic [2:0] f, input logic [63:0] d);
    int nb;
    logic [63:0] mask, v;
    nb   = 8 << f[1:0];
    mask = (nb == 64) ? {64{1'b1}} : ((64'd1 << nb) - 64'd1);
    v    = d & mask;
    if (!f[2] && nb < 64 && d[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Launches one instruction from idle and watches it to instr_done or mem_err.
  // mem_ready stays low for the first dly MEM cycles, then high.
  task automatic run_instr(input logic [4:0] r, input logic w, input logic m,
                           input logic [2:0] f, input logic [63:0] a,
                           input logic [63:0] d, input int dly, output obs_t o);
    int low;
    o = '{default: 0};
    low = 0;
    rd_in = r; reg_write_in = w; mem_to_reg = m; funct3 = f;
    alu_result = a; mem_rdata = d; mem_ready = 1'b0; instr_valid = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      o.cyc = c;
      if (c <= 3 && counter != 3'(c)) o.seq_bad = 1'b1;
      if (regWrite && counter != 3'd4) o.rw_bad = 1'b1;
      if (counter == 3'd3) begin
        o.p3++;
        mem_ready = (low >= dly);
        if (!mem_ready) low++;
      end else mem_ready = 1'b0;
      if (counter == 3'd4) begin
        o.seen4 = 1'b1; o.rd = rd; o.wval = wval; o.rw = regWrite;
      end
      if (mem_err) begin o.err = 1'b1; break; end
      if (instr_done) begin o.done = 1'b1; break; end
      if (c == 100) o.to = 1'b1;
    end
  endtask

  task automatic verify(input string nm, input obs_t o, input logic exp_err, input int exp_p3,
                        input logic [4:0] er, input logic [63:0] ew, input logic erw);
    chk({nm, ".timeout"}, o.to, 1'b0);
    chk({nm, ".seq"}, o.seq_bad, 1'b0);
    chk({nm, ".mem_err"}, o.err, exp_err);
    chk({nm, ".done"}, o.done, !exp_err);
    chk({nm, ".wb_seen"}, o.seen4, !exp_err);
    chk({nm, ".rw_outside_wb"}, o.rw_bad, 1'b0);
    chk({nm, ".mem_cycles"}, 64'(o.p3), 64'(exp_p3));
    chk({nm, ".latency"}, 64'(o.cyc), 64'(exp_err ? 3 + exp_p3 : 4 + exp_p3));
    if (!exp_err) begin
      chk({nm, ".rd"}, o.rd, er);
      chk({nm, ".wval"}, o.wval, ew);
      chk({nm, ".regWrite"}, o.rw, erw);
    end
    @(negedge clk);
    chk({nm, ".pulse_clear"}, {instr_done, mem_err, regWrite}, 3'b000);
    chk({nm, ".idle"}, counter, 3'd0);
  endtask

  vec_t vt[$];
  obs_t o;

  initial begin
    int ok, pulses;
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; rd_in = '0; reg_write_in = 1'b0;
    mem_to_reg = 1'b0; funct3 = '0; alu_result = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outs", {counter, rd, regWrite, instr_done, mem_err}, '0);
    chk("reset.wval", wval, 64'd0);
    rst = 1'b0;

    vt.push_back('{5'd5,  1, 0, 3'b000, 64'h1234, 64'h0, 64'h1234, 1});
    vt.push_back('{5'd7,  1, 1, 3'b000, 64'h55, 64'h80, 64'hFFFF_FFFF_FFFF_FF80, 1});
    vt.push_back('{5'd7,  1, 1, 3'b100, 64'h55, 64'h80, 64'h80, 1});
    vt.push_back('{5'd8,  1, 1, 3'b010, 64'h55, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 1});
    vt.push_back('{5'd9,  1, 1, 3'b001, 64'h55, 64'hDEAD_BEEF_CAFE_8001, 64'hFFFF_FFFF_FFFF_8001, 1});
    vt.push_back('{5'd10, 1, 1, 3'b101, 64'h55, 64'hDEAD_BEEF_CAFE_8001, 64'h8001, 1});
    vt.push_back('{5'd11, 1, 1, 3'b110, 64'h55, 64'hDEAD_BEEF_CAFE_8001, 64'hCAFE_8001, 1});
    vt.push_back('{5'd12, 1, 1, 3'b011, 64'h55, 64'hDEAD_BEEF_CAFE_8001, 64'hDEAD_BEEF_CAFE_8001, 1});
    vt.push_back('{5'd13, 1, 1, 3'b111, 64'h55, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1});
    vt.push_back('{5'd14, 1, 1, 3'b010, 64'h55, 64'h1234_5678_7FFF_FFFF, 64'h7FFF_FFFF, 1});
    vt.push_back('{5'd0,  1, 0, 3'b000, 64'hBEEF, 64'h0, 64'hBEEF, 0});
    vt.push_back('{5'd9,  0, 0, 3'b000, 64'hF00D, 64'h0, 64'hF00D, 0});
    vt.push_back('{5'd31, 1, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    foreach (vt[i]) begin
      run_instr(vt[i].r, vt[i].w, vt[i].m, vt[i].f, vt[i].alu, vt[i].dat, 0, o);
      verify($sformatf("vec%0d", i), o, 1'b0, 1, vt[i].r, vt[i].exp_wval, vt[i].exp_rw);
    end

    run_instr(5'd4, 1, 1, 3'b000, 64'h0, 64'h7F, 3, o);
    verify("wait3", o, 1'b0, 4, 5'd4, 64'h7F, 1'b1);
    run_instr(5'd4, 1, 1, 3'b000, 64'h0, 64'h7F, TMO - 1, o);
    verify("ready_at_limit", o, 1'b0, TMO, 5'd4, 64'h7F, 1'b1);
    run_instr(5'd6, 1, 1, 3'b011, 64'h0, 64'h1, 1000, o);
    verify("timeout", o, 1'b1, TMO, 5'd0, 64'h0, 1'b0);

    // Reset dominates stall in MEM.
    rd_in = 5'd3; reg_write_in = 1'b1; mem_to_reg = 1'b1; mem_ready = 1'b0; instr_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); instr_valid = 1'b0;
      if (counter == 3'd3) begin ok = 1; break; end
    end
    chk("rst_mem.reach3", 64'(ok), 64'd1);
    stall = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mem.outs", {counter, rd, regWrite, mem_err, instr_done}, '0);
    chk("rst_mem.wval", wval, 64'd0);
    stall = 1'b0; rst = 1'b0;
    ok = 0;
    repeat (5) begin @(negedge clk); if (regWrite || counter != 3'd0) ok = 1; end
    chk("rst_mem.no_write", 64'(ok), 64'd0);

    // Two stall cycles in WB.
    rd_in = 5'd12; reg_write_in = 1'b1; mem_to_reg = 1'b0; alu_result = 64'hABCD; instr_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); instr_valid = 1'b0;
      if (counter == 3'd4) begin ok = 1; break; end
    end
    chk("stall_wb.reach4", 64'(ok), 64'd1);
    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_wb.hold", {counter, rd, regWrite, instr_done}, {3'd4, 5'd12, 1'b1, 1'b0});
      chk("stall_wb.wval", wval, 64'hABCD);
    end
    stall = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (instr_done) pulses++; end
    chk("stall_wb.one_pulse", 64'(pulses), 64'd1);
    chk("stall_wb.idle", {counter, regWrite}, 4'd0);

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  r;
      logic        w, m, eerr;
      logic [2:0]  f;
      logic [63:0] a, d;
      int          dly, ep3;
      r = 5'($urandom); w = 1'($urandom); m = 1'($urandom); f = 3'($urandom);
      a = {$urandom, $urandom}; d = {$urandom, $urandom};
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 1) : $urandom_range(0, 5);
      eerr = m && (dly >= TMO);
      ep3  = !m ? 1 : (eerr ? TMO : dly + 1);
      run_instr(r, w, m, f, a, d, dly, o);
      verify($sformatf("rnd%0d", i), o, eerr, ep3, r, m ? ref_ext(f, d) : a, w && (r != 5'd0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
